membrane_integrator: RTL and testbench

- Upstream stage of the spike/threshold selector in the digital neuron datapath.
- Once per timestep, the block accumulates N_INPUTS weighted synaptic events, applies a shift-based leak to the stored membrane potential, and saturates the result to 21-bit signed. It presents the potential as v_out, which drives the selector's compare and pass-through operands.
- The selector's chosen value (pass-through or reset) returns on v_next and becomes the new stored potential on v_ack.
- Potential format: 21-bit two's complement, 9 fractional bits. The 1.0 step is 512 and the firing threshold is 7680.

---
 rtl/membrane_integrator.sv | 136 +++++++++++++
 tb/tb_membrane_integrator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/membrane_integrator.sv
// rtl/membrane_integrator.sv - per-timestep synaptic integration with shift leak and saturation
//
// Purpose: once per timestep, sums N_INPUTS weighted synaptic events and leaks the
// stored membrane potential by v_reg >>> LEAK_SHIFT. The result is clipped to 21-bit
// signed and presented on v_out. The downstream selector returns the value to keep on
// v_next, and that value is committed on v_ack.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   step_start          one-cycle pulse that begins a timestep (honoured in IDLE only)
//   syn_valid/syn_ready sample handshake; syn_spike gates syn_weight into the sum
//   syn_weight          signed weight, 9 fractional bits
//   v_out, v_valid      leaked+integrated potential, held until v_ack
//   v_next, v_ack       selector result and its commit strobe
//   busy                high outside IDLE
//   sat_flag            one-cycle pulse when the LEAK result was clipped
module membrane_integrator #(
  parameter int N_INPUTS   = 16,
  parameter int WEIGHT_W   = 12,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_start,
  input  logic                       syn_valid,
  output logic                       syn_ready,
  input  logic                       syn_spike,
  input  logic signed [WEIGHT_W-1:0] syn_weight,
  output logic signed [20:0]         v_out,
  output logic                       v_valid,
  input  logic signed [20:0]         v_next,
  input  logic                       v_ack,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int CNT_W = $clog2(N_INPUTS);
  localparam int ACC_W = WEIGHT_W + CNT_W + 1;
  // Two guard bits above the wider operand keep v - leak + acc from wrapping.
  localparam int RW    = ((ACC_W > 21) ? ACC_W : 21) + 2;

  localparam logic signed [RW-1:0] V_MAX = {{(RW-20){1'b0}}, {20{1'b1}}};
  localparam logic signed [RW-1:0] V_MIN = {{(RW-20){1'b1}}, {20{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, LEAK, OUT} state_t;

  state_t                    state;
  logic signed [20:0]        v_reg;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;

  logic                      handshake;
  logic signed [ACC_W-1:0]   w_ext;
  logic signed [20:0]        leak_amt;
  logic signed [RW-1:0]      v_ext;
  logic signed [RW-1:0]      leak_ext;
  logic signed [RW-1:0]      acc_ext;
  logic signed [RW-1:0]      r_full;
  logic                      over;
  logic                      under;
  logic signed [20:0]        r_sat;

  assign syn_ready = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign handshake = syn_valid && syn_ready;

  assign w_ext    = {{(ACC_W-WEIGHT_W){syn_weight[WEIGHT_W-1]}}, syn_weight};
  // Arithmetic shift floors, so negative potentials also decay toward zero.
  assign leak_amt = v_reg >>> LEAK_SHIFT;
  assign v_ext    = {{(RW-21){v_reg[20]}}, v_reg};
  assign leak_ext = {{(RW-21){leak_amt[20]}}, leak_amt};
  assign acc_ext  = {{(RW-ACC_W){acc[ACC_W-1]}}, acc};
  assign r_full   = v_ext - leak_ext + acc_ext;

  assign over  = (r_full > V_MAX);
  assign under = (r_full < V_MIN);

  always_comb begin
    r_sat = r_full[20:0];
    if (over) begin
      r_sat = 21'h0FFFFF;
    end else if (under) begin
      r_sat = 21'h100000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      v_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      v_out    <= '0;
      v_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (step_start) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (handshake) begin
            if (syn_spike) begin
              acc <= acc + w_ext;
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N_INPUTS - 1)) begin
              state <= LEAK;
            end
          end
        end
        LEAK: begin
          v_out    <= r_sat;
          v_valid  <= 1'b1;
          sat_flag <= over || under;
          state    <= OUT;
        end
        OUT: begin
          // step_start in the same cycle is deliberately dropped: we land in IDLE.
          if (v_ack) begin
            v_reg   <= v_next;
            v_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membrane_integrator.sv
// tb/tb_membrane_integrator.sv - directed table-driven bench for membrane_integrator
module tb_membrane_integrator;

  logic clk = 1'b0;
  logic rst_n;
  logic step_start;
  logic syn_valid;
  logic syn_spike;
  logic signed [11:0] syn_weight;
  logic signed [20:0] v_next;
  logic v_ack;

  logic syn_ready_a, v_valid_a, busy_a, sat_a;
  logic syn_ready_b, v_valid_b, busy_b, sat_b;
  logic signed [20:0] v_out_a, v_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  membrane_integrator #(.N_INPUTS(16), .WEIGHT_W(12), .LEAK_SHIFT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .syn_valid(syn_valid),
    .syn_ready(syn_ready_a), .syn_spike(syn_spike), .syn_weight(syn_weight),
    .v_out(v_out_a), .v_valid(v_valid_a), .v_next(v_next), .v_ack(v_ack),
    .busy(busy_a), .sat_flag(sat_a)
  );

  membrane_integrator #(.N_INPUTS(16), .WEIGHT_W(12), .LEAK_SHIFT(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .syn_valid(syn_valid),
    .syn_ready(syn_ready_b), .syn_spike(syn_spike), .syn_weight(syn_weight),
    .v_out(v_out_b), .v_valid(v_valid_b), .v_next(v_next), .v_ack(v_ack),
    .busy(busy_b), .sat_flag(sat_b)
  );

  typedef struct {
    string              nm;
    logic signed [20:0] v_init;
    logic [15:0]        spikes;
    logic [15:0][11:0]  w;
    bit                 inst_b;
    int                 exp_v;
    bit                 exp_sat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sp, input logic [11:0] w);
    int guard;
    syn_valid  = 1'b1;
    syn_spike  = sp;
    syn_weight = w;
    guard = 0;
    while (!syn_ready_a && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 0, 1);
    tick();
    syn_valid = 1'b0;
  endtask

  task automatic run_step(input logic [15:0] sp, input logic [15:0][11:0] w, input bit gaps,
                          output logic signed [20:0] va, output logic signed [20:0] vb,
                          output logic sa, output logic sb);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int g = 0; g < n; g++) begin
          step_start = 1'b1;
          tick();
        end
        step_start = 1'b0;
      end
      send(sp[k], w[k]);
    end
    chk("v_valid_low_after_last_hs", int'(v_valid_a), 0);
    tick();
    chk("v_valid_latency_a", int'(v_valid_a), 1);
    chk("v_valid_latency_b", int'(v_valid_b), 1);
    va = v_out_a;
    vb = v_out_b;
    sa = sat_a;
    sb = sat_b;
    tick();
    chk("sat_pulse_one_cycle", int'(sat_a | sat_b), 0);
    chk("v_valid_held", int'(v_valid_a & v_valid_b), 1);
  endtask

  task automatic ack(input logic signed [20:0] nv, input logic with_start);
    v_next     = nv;
    v_ack      = 1'b1;
    step_start = with_start;
    tick();
    v_ack      = 1'b0;
    step_start = 1'b0;
    v_next     = 21'h0ABCD;
    chk("ack_v_valid_low", int'(v_valid_a | v_valid_b), 0);
    chk("ack_idle", int'(busy_a | busy_b), 0);
  endtask

  logic signed [20:0] va, vb, held;
  logic sa, sb;
  logic [15:0][11:0] w0;
  logic [15:0][11:0] wm;
  logic [15:0][11:0] wbp;
  int exp_bp;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    w0 = '0;
    wm = '0;
    wm[0] = 12'd1000;
    wm[1] = 12'hE70;
    wm[2] = 12'hDA8;
    wm[3] = 12'h7FF;

    vecs[0] = '{"integ",     21'sd0,     16'h000F, {16{12'd512}},  1'b0, 2048,     1'b0};
    vecs[1] = '{"leak_pos",  21'sd8192,  16'h0000, w0,             1'b0, 7680,     1'b0};
    vecs[2] = '{"leak_zero", 21'sd0,     16'h0000, w0,             1'b0, 0,        1'b0};
    vecs[3] = '{"leak_neg",  -21'sd100,  16'h0000, w0,             1'b0, -93,      1'b0};
    vecs[4] = '{"leak_m1",   -21'sd1,    16'h0000, w0,             1'b0, 0,        1'b0};
    vecs[5] = '{"mixed",     21'sd512,   16'h0007, wm,             1'b0, 480,      1'b0};
    vecs[6] = '{"sat_hi",    21'sd1048575, 16'hFFFF, {16{12'h7FF}}, 1'b1, 1048575, 1'b1};
    vecs[7] = '{"sat_lo",    -21'sd1048576, 16'hFFFF, {16{12'h800}}, 1'b1, -1048576, 1'b1};
    vecs[8] = '{"edge_hi",   21'sd1048575, 16'h0000, w0,           1'b1, 1048575,  1'b0};
    vecs[9] = '{"big_leak",  21'sd1048575, 16'h0000, w0,           1'b0, 983040,   1'b0};

    rst_n = 1'b0; step_start = 1'b0; syn_valid = 1'b0; syn_spike = 1'b0;
    syn_weight = '0; v_next = '0; v_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_ready", int'(syn_ready_a), 0);
    chk("rst_v_valid", int'(v_valid_a), 0);
    chk("rst_v_out", int'(v_out_a), 0);

    run_step(16'h0000, w0, 1'b0, va, vb, sa, sb);
    chk("prime_v_out_a", int'(va), 0);
    chk("prime_v_out_b", int'(vb), 0);
    ack(vecs[0].v_init, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_step(vecs[i].spikes, vecs[i].w, 1'b0, va, vb, sa, sb);
      chk({vecs[i].nm, "_v_out"}, vecs[i].inst_b ? int'(vb) : int'(va), vecs[i].exp_v);
      chk({vecs[i].nm, "_sat"}, int'(vecs[i].inst_b ? sb : sa), int'(vecs[i].exp_sat));
      ack((i < 9) ? vecs[i+1].v_init : 21'sd3000, 1'b0);
    end

    // Backpressure: random sample gaps, step_start pulses in ACCUM/OUT, delayed ack.
    exp_bp = 3000 - (3000 >>> 4);
    for (int k = 0; k < 16; k++) begin
      wbp[k] = 12'(k * 37 - 200);
      if (16'hA5A5 & (16'h1 << k)) exp_bp += k * 37 - 200;
    end
    run_step(16'hA5A5, wbp, 1'b1, va, vb, sa, sb);
    chk("bp_v_out", int'(va), exp_bp);
    held = v_out_a;
    for (int c = 0; c < 6; c++) begin
      step_start = c[0];
      syn_valid  = 1'b1;
      tick();
      chk("bp_hold_v_out", int'(v_out_a), int'(held));
      chk("bp_hold_valid", int'(v_valid_a), 1);
    end
    step_start = 1'b0;
    syn_valid  = 1'b0;
    ack(21'sd1600, 1'b1);
    chk("v_out_kept_after_ack", int'(v_out_a), int'(held));
    tick();
    chk("no_start_with_ack", int'(busy_a), 0);

    // v_ack outside OUT must not touch the stored potential.
    v_next = 21'sd999;
    v_ack  = 1'b1;
    tick();
    v_ack  = 1'b0;
    chk("ack_in_idle_busy", int'(busy_a), 0);
    run_step(16'h0000, w0, 1'b0, va, vb, sa, sb);
    chk("ack_in_idle_ignored", int'(va), 1500);
    ack(21'sd5000, 1'b0);

    // Reset mid-ACCUM discards partial sum and stored potential.
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int k = 0; k < 5; k++) send(1'b1, 12'd100);
    rst_n = 1'b0;
    #2;
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_ready", int'(syn_ready_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_v_valid", int'(v_valid_a), 0);
    chk("mid_rst_v_out", int'(v_out_a), 0);
    chk("mid_rst_sat", int'(sat_a), 0);
    run_step(16'h0000, w0, 1'b0, va, vb, sa, sb);
    chk("post_rst_v_out_a", int'(va), 0);
    chk("post_rst_v_out_b", int'(vb), 0);
    ack(21'sd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
